// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the EX-stage ALU issue controller.
// Contents: RV32I major opcodes, the ALUop encoding seen by the ALU,
// controller state encoding, forwarding select encoding, and an opcode
// decoder that reports which source registers an instruction reads.
package alu_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ALU_MEM    = 3'd0,
        ALU_BRANCH = 3'd1,
        ALU_OP     = 3'd2,
        ALU_OPIMM  = 3'd3,
        ALU_LUI    = 3'd4,
        ALU_AUIPC  = 3'd5,
        ALU_JAL    = 3'd6,
        ALU_JALR   = 3'd7
    } aluop_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RESOLVE = 2'd1,
        FLUSH   = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic   legal;
        aluop_t aluop;
        logic   uses_rs1;
        logic   uses_rs2;
        logic   is_load;
        logic   is_ctrl;   // branch or jump: needs resolution before more issue
    } decode_t;

    function automatic decode_t decode_opcode(input logic [6:0] opcode);
        decode_t d;
        d.legal    = 1'b1;
        d.aluop    = ALU_MEM;
        d.uses_rs1 = 1'b0;
        d.uses_rs2 = 1'b0;
        d.is_load  = 1'b0;
        d.is_ctrl  = 1'b0;
        case (opcode)
            OPC_LOAD:   begin d.uses_rs1 = 1'b1; d.is_load = 1'b1; end
            OPC_STORE:  begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
            OPC_BRANCH: begin
                d.aluop = ALU_BRANCH; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.is_ctrl = 1'b1;
            end
            OPC_OP:     begin d.aluop = ALU_OP; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
            OPC_OPIMM:  begin d.aluop = ALU_OPIMM; d.uses_rs1 = 1'b1; end
            OPC_LUI:    d.aluop = ALU_LUI;
            OPC_AUIPC:  d.aluop = ALU_AUIPC;
            OPC_JAL:    begin d.aluop = ALU_JAL; d.is_ctrl = 1'b1; end
            OPC_JALR:   begin d.aluop = ALU_JALR; d.uses_rs1 = 1'b1; d.is_ctrl = 1'b1; end
            default:    d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_fwd_unit.sv
// Combinational hazard logic for the instruction currently in ID.
// Inputs : rs1/rs2 of the ID instruction and whether each is read,
//          rd/regwrite of EX/MEM and MEM/WB, rd of a LOAD sitting in EX.
// Outputs: fwd_a/fwd_b operand source selects, load_use stall request.
module fwd_unit
    import alu_ctrl_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    input  logic       ex_load_valid,
    input  logic [4:0] ex_load_rd,
    output fwd_sel_t   fwd_a,
    output fwd_sel_t   fwd_b,
    output logic       load_use
);

    // x0 is never forwarded; the younger stage (EX/MEM) wins over MEM/WB.
    function automatic fwd_sel_t pick(input logic [4:0] rs, input logic [4:0] m_rd,
                                      input logic m_we, input logic [4:0] w_rd,
                                      input logic w_we);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (rs != 5'd0) begin
            if (m_we && (m_rd == rs))      sel = FWD_MEM;
            else if (w_we && (w_rd == rs)) sel = FWD_WB;
        end
        return sel;
    endfunction

    assign fwd_a = pick(rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    assign fwd_b = pick(rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);

    // A load result is not available for forwarding until it leaves MEM,
    // so a dependent instruction directly behind it has to wait a cycle.
    assign load_use = ex_load_valid && (ex_load_rd != 5'd0) &&
                      ((uses_rs1 && (rs1 == ex_load_rd)) ||
                       (uses_rs2 && (rs2 == ex_load_rd)));

endmodule

// File: rtl/alu_issue_ctrl.sv
// EX-stage issue controller for the RV32I ALU.
// Decodes the ID instruction into ALUop/func3/func7, issues one op per cycle
// (registered), resolves branches/jumps from the ALU's registered result,
// redirects fetch and squashes the wrong-path ID slots, and produces the
// load-use stall and operand forwarding selects.
// Ports:
//   i_clk, i_reset (sync, active-low)
//   ID handshake   : i_id_valid, o_id_ready, i_opcode, i_func3, i_func7b5, i_rs1, i_rs2, i_rd
//   pipeline state : i_mem_rd/i_mem_regwrite (EX/MEM), i_wb_rd/i_wb_regwrite (MEM/WB)
//   ALU feedback   : i_alu_branch, i_alu_result
//   ALU issue      : o_alu_op, o_func3, o_func7, o_ex_valid, o_fwd_a, o_fwd_b
//   control flow   : o_redirect, o_target, o_squash, o_illegal
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_id_valid,
    output logic            o_id_ready,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_func3,
    input  logic            i_func7b5,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    input  logic [4:0]      i_rd,
    input  logic [4:0]      i_mem_rd,
    input  logic            i_mem_regwrite,
    input  logic [4:0]      i_wb_rd,
    input  logic            i_wb_regwrite,
    input  logic            i_alu_branch,
    input  logic [XLEN-1:0] i_alu_result,
    output logic [2:0]      o_alu_op,
    output logic [2:0]      o_func3,
    output logic            o_func7,
    output logic            o_ex_valid,
    output logic [1:0]      o_fwd_a,
    output logic [1:0]      o_fwd_b,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_target,
    output logic            o_squash,
    output logic            o_illegal
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    ctrl_state_t       state;
    logic              resolve_phase;  // 0: op in ALU, 1: ALU result visible
    logic              pend_jump;      // pending op redirects unconditionally
    logic              pend_jalr;
    logic [CNT_W-1:0]  flush_cnt;

    aluop_t            alu_op_q;
    logic [2:0]        func3_q;
    logic              func7_q;
    logic              ex_valid_q;
    fwd_sel_t          fwd_a_q;
    fwd_sel_t          fwd_b_q;
    logic              redirect_q;
    logic [XLEN-1:0]   target_q;
    logic              illegal_q;
    logic              ex_load_q;
    logic [4:0]        ex_load_rd_q;

    decode_t           dec;
    fwd_sel_t          fwd_a;
    fwd_sel_t          fwd_b;
    logic              load_use;
    logic              id_ready;
    logic              accept;
    logic              issue;
    logic              func7_dec;

    assign dec = decode_opcode(i_opcode);

    fwd_unit u_fwd (
        .rs1          (i_rs1),
        .rs2          (i_rs2),
        .uses_rs1     (dec.uses_rs1),
        .uses_rs2     (dec.uses_rs2),
        .mem_rd       (i_mem_rd),
        .mem_regwrite (i_mem_regwrite),
        .wb_rd        (i_wb_rd),
        .wb_regwrite  (i_wb_regwrite),
        .ex_load_valid(ex_load_q),
        .ex_load_rd   (ex_load_rd_q),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .load_use     (load_use)
    );

    // Nothing is accepted while reset is held, so no slot is lost across it.
    always_comb begin
        // NOTE: assign a default before any branch so every path drives the
        // signal; a missing path would infer a latch.
        id_ready = 1'b0;
        if (i_reset) begin
            case (state)
                RUN:     id_ready = !load_use;
                FLUSH:   id_ready = 1'b1;
                default: id_ready = 1'b0;
            endcase
        end
    end

    // func7 only matters for OP and the shift-right OP-IMM; for every other
    // OP-IMM instr[30] is immediate data, so ADDI must never look like SUB.
    always_comb begin
        func7_dec = 1'b0;
        if ((i_opcode == OPC_OP) || ((i_opcode == OPC_OPIMM) && (i_func3 == 3'd5)))
            func7_dec = i_func7b5;
    end

    assign accept = i_id_valid && id_ready;
    // Squashed slots (FLUSH) and illegal opcodes are accepted but go out as bubbles.
    assign issue  = accept && (state == RUN) && dec.legal;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of every other register.
            state         <= RUN;
            resolve_phase <= 1'b0;
            pend_jump     <= 1'b0;
            pend_jalr     <= 1'b0;
            flush_cnt     <= '0;
            alu_op_q      <= ALU_MEM;
            func3_q       <= 3'd0;
            func7_q       <= 1'b0;
            ex_valid_q    <= 1'b0;
            fwd_a_q       <= FWD_RF;
            fwd_b_q       <= FWD_RF;
            redirect_q    <= 1'b0;
            target_q      <= '0;
            illegal_q     <= 1'b0;
            ex_load_q     <= 1'b0;
            ex_load_rd_q  <= 5'd0;
        end else begin
            // Issue registers: bubbles are driven as all-zero ops.
            alu_op_q     <= issue ? dec.aluop : ALU_MEM;
            func3_q      <= issue ? i_func3   : 3'd0;
            func7_q      <= issue ? func7_dec : 1'b0;
            ex_valid_q   <= issue;
            fwd_a_q      <= issue ? fwd_a     : FWD_RF;
            fwd_b_q      <= issue ? fwd_b     : FWD_RF;
            ex_load_q    <= issue && dec.is_load;
            ex_load_rd_q <= i_rd;
            illegal_q    <= accept && (state == RUN) && !dec.legal;
            redirect_q   <= 1'b0;

            case (state)
                RUN: begin
                    if (issue && dec.is_ctrl) begin
                        state         <= RESOLVE;
                        resolve_phase <= 1'b0;
                        pend_jump     <= (dec.aluop == ALU_JAL) || (dec.aluop == ALU_JALR);
                        pend_jalr     <= (dec.aluop == ALU_JALR);
                    end
                end
                RESOLVE: begin
                    if (!resolve_phase) begin
                        resolve_phase <= 1'b1;
                    end else if (pend_jump || i_alu_branch) begin
                        redirect_q <= 1'b1;
                        target_q   <= pend_jalr ? {i_alu_result[XLEN-1:1], 1'b0} : i_alu_result;
                        flush_cnt  <= CNT_W'(FLUSH_CYCLES);
                        state      <= FLUSH;
                    end else begin
                        state <= RUN;
                    end
                end
                FLUSH: begin
                    // Only slots that actually arrive count as discarded.
                    if (accept) begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                        if (flush_cnt == CNT_W'(1))
                            state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign o_id_ready = id_ready;
    assign o_alu_op   = alu_op_q;
    assign o_func3    = func3_q;
    assign o_func7    = func7_q;
    assign o_ex_valid = ex_valid_q;
    assign o_fwd_a    = fwd_a_q;
    assign o_fwd_b    = fwd_b_q;
    assign o_redirect = redirect_q;
    assign o_target   = target_q;
    assign o_squash   = (state == FLUSH);
    assign o_illegal  = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl (FLUSH_CYCLES=2, XLEN=32).
module tb_alu_issue_ctrl;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_id_valid;
    logic        o_id_ready;
    logic [6:0]  i_opcode;
    logic [2:0]  i_func3;
    logic        i_func7b5;
    logic [4:0]  i_rs1, i_rs2, i_rd;
    logic [4:0]  i_mem_rd, i_wb_rd;
    logic        i_mem_regwrite, i_wb_regwrite;
    logic        i_alu_branch;
    logic [31:0] i_alu_result;
    logic [2:0]  o_alu_op, o_func3;
    logic        o_func7, o_ex_valid;
    logic [1:0]  o_fwd_a, o_fwd_b;
    logic        o_redirect;
    logic [31:0] o_target;
    logic        o_squash, o_illegal;

    int errors = 0;
    int checks = 0;

    alu_issue_ctrl #(.FLUSH_CYCLES(2), .XLEN(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
        .i_opcode(i_opcode), .i_func3(i_func3), .i_func7b5(i_func7b5),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
        .i_mem_rd(i_mem_rd), .i_mem_regwrite(i_mem_regwrite),
        .i_wb_rd(i_wb_rd), .i_wb_regwrite(i_wb_regwrite),
        .i_alu_branch(i_alu_branch), .i_alu_result(i_alu_result),
        .o_alu_op(o_alu_op), .o_func3(o_func3), .o_func7(o_func7), .o_ex_valid(o_ex_valid),
        .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b), .o_redirect(o_redirect), .o_target(o_target),
        .o_squash(o_squash), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f7, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd);
        i_id_valid = v;
        i_opcode   = opc;
        i_func3    = f3;
        i_func7b5  = f7;
        i_rs1      = rs1;
        i_rs2      = rs2;
        i_rd       = rd;
    endtask

    task automatic idle;
        set_id(1'b0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic set_fwd(input logic [4:0] mrd, input logic mw, input logic [4:0] wrd, input logic ww);
        i_mem_rd       = mrd;
        i_mem_regwrite = mw;
        i_wb_rd        = wrd;
        i_wb_regwrite  = ww;
    endtask

    task automatic test_reset;
        i_reset = 1'b0;
        idle();
        set_fwd(5'd0, 1'b0, 5'd0, 1'b0);
        i_alu_branch = 1'b0;
        i_alu_result = 32'd0;
        tick();
        tick();
        checks++; if (o_id_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", o_id_ready); end
        checks++; if (o_ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0b want 0", o_ex_valid); end
        checks++; if (o_redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %0b want 0", o_redirect); end
        checks++; if (o_squash !== 1'b0) begin errors++; $display("FAIL reset_squash: got %0b want 0", o_squash); end
        checks++; if (o_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %0b want 0", o_illegal); end
        checks++; if (o_alu_op !== 3'd0) begin errors++; $display("FAIL reset_alu_op: got %0d want 0", o_alu_op); end
        checks++; if (o_target !== 32'd0) begin errors++; $display("FAIL reset_target: got %h want 0", o_target); end
        i_reset = 1'b1;
        #1;
        checks++; if (o_id_ready !== 1'b1) begin errors++; $display("FAIL run_ready: got %0b want 1", o_id_ready); end
        tick();
    endtask

    task automatic test_decode;
        set_id(1'b1, OP_OP, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3);          // SUB-form ADD x3,x1,x2
        #1;
        checks++; if (o_id_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %0b want 1", o_id_ready); end
        tick();
        set_id(1'b1, OP_OPIMM, 3'd0, 1'b1, 5'd1, 5'd0, 5'd4);       // ADDI with instr[30]=1
        checks++; if (o_alu_op !== 3'd2) begin errors++; $display("FAIL add_alu_op: got %0d want 2", o_alu_op); end
        checks++; if (o_func7 !== 1'b1) begin errors++; $display("FAIL add_func7: got %0b want 1", o_func7); end
        checks++; if (o_ex_valid !== 1'b1) begin errors++; $display("FAIL add_ex_valid: got %0b want 1", o_ex_valid); end
        tick();
        set_id(1'b1, OP_OPIMM, 3'd5, 1'b1, 5'd1, 5'd0, 5'd4);       // SRAI
        checks++; if (o_alu_op !== 3'd3) begin errors++; $display("FAIL addi_alu_op: got %0d want 3", o_alu_op); end
        checks++; if (o_func7 !== 1'b0) begin errors++; $display("FAIL addi_func7: got %0b want 0", o_func7); end
        tick();
        idle();
        checks++; if (o_func7 !== 1'b1) begin errors++; $display("FAIL srai_func7: got %0b want 1", o_func7); end
        checks++; if (o_func3 !== 3'd5) begin errors++; $display("FAIL srai_func3: got %0d want 5", o_func3); end
        tick();
        checks++; if (o_ex_valid !== 1'b0) begin errors++; $display("FAIL idle_bubble: got %0b want 0", o_ex_valid); end
    endtask

    task automatic test_branch_taken;
        set_id(1'b1, OP_BRANCH, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0);      // BEQ
        tick();
        set_id(1'b1, OP_OP, 3'd0, 1'b0, 5'd4, 5'd5, 5'd6);
        #1;
        checks++; if (o_alu_op !== 3'd1) begin errors++; $display("FAIL beq_alu_op: got %0d want 1", o_alu_op); end
        checks++; if (o_id_ready !== 1'b0) begin errors++; $display("FAIL beq_resolve_ready: got %0b want 0", o_id_ready); end
        tick();
        i_alu_branch = 1'b1;
        i_alu_result = 32'h100;
        #1;
        checks++; if (o_ex_valid !== 1'b0) begin errors++; $display("FAIL beq_bubble: got %0b want 0", o_ex_valid); end
        tick();
        i_alu_branch = 1'b0;
        i_alu_result = 32'd0;
        checks++; if (o_redirect !== 1'b1) begin errors++; $display("FAIL beq_redirect: got %0b want 1", o_redirect); end
        checks++; if (o_target !== 32'h100) begin errors++; $display("FAIL beq_target: got %h want 100", o_target); end
        checks++; if (o_squash !== 1'b1 || o_id_ready !== 1'b1) begin errors++; $display("FAIL beq_squash1: got squash=%0b ready=%0b want 1/1", o_squash, o_id_ready); end
        tick();
        checks++; if (o_redirect !== 1'b0) begin errors++; $display("FAIL beq_redirect_pulse: got %0b want 0", o_redirect); end
        checks++; if (o_squash !== 1'b1) begin errors++; $display("FAIL beq_squash2: got %0b want 1", o_squash); end
        tick();
        checks++; if (o_squash !== 1'b0 || o_ex_valid !== 1'b0) begin errors++; $display("FAIL beq_back_to_run: got squash=%0b ex_valid=%0b want 0/0", o_squash, o_ex_valid); end
        tick();
        idle();
        checks++; if (o_ex_valid !== 1'b1 || o_alu_op !== 3'd2) begin errors++; $display("FAIL beq_after_issue: got ex_valid=%0b alu_op=%0d want 1/2", o_ex_valid, o_alu_op); end
        tick();
    endtask

    task automatic test_branch_not_taken;
        int stalls;
        set_id(1'b1, OP_BRANCH, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0);      // BNE
        i_alu_branch = 1'b0;
        i_alu_result = 32'h40;
        tick();
        set_id(1'b1, OP_OP, 3'd0, 1'b0, 5'd4, 5'd5, 5'd6);
        stalls = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (o_id_ready) break;
            stalls++;
            @(posedge i_clk);
        end
        checks++; if (stalls !== 2) begin errors++; $display("FAIL bne_stalls: got %0d want 2", stalls); end
        checks++; if (o_redirect !== 1'b0 || o_squash !== 1'b0) begin errors++; $display("FAIL bne_no_redirect: got redirect=%0b squash=%0b want 0/0", o_redirect, o_squash); end
        tick();
        idle();
        i_alu_result = 32'd0;
        checks++; if (o_ex_valid !== 1'b1) begin errors++; $display("FAIL bne_next_issue: got %0b want 1", o_ex_valid); end
        tick();
    endtask

    task automatic test_jalr;
        set_id(1'b1, OP_JALR, 3'd0, 1'b0, 5'd1, 5'd0, 5'd1);
        tick();
        idle();
        checks++; if (o_alu_op !== 3'd7) begin errors++; $display("FAIL jalr_alu_op: got %0d want 7", o_alu_op); end
        tick();
        i_alu_result = 32'h203;
        tick();
        i_alu_result = 32'd0;
        checks++; if (o_redirect !== 1'b1 || o_target !== 32'h202) begin errors++; $display("FAIL jalr_target: got redirect=%0b target=%h want 1/202", o_redirect, o_target); end
        tick();
        // No ID slot arrived, so the flush window must still be open.
        checks++; if (o_squash !== 1'b1) begin errors++; $display("FAIL jalr_hold_flush: got %0b want 1", o_squash); end
        set_id(1'b1, OP_OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3);
        tick();
        tick();
        idle();
        checks++; if (o_squash !== 1'b0 || o_ex_valid !== 1'b0) begin errors++; $display("FAIL jalr_flush_done: got squash=%0b ex_valid=%0b want 0/0", o_squash, o_ex_valid); end
        tick();
    endtask

    task automatic test_load_use;
        set_fwd(5'd0, 1'b0, 5'd0, 1'b0);
        set_id(1'b1, OP_LOAD, 3'd2, 1'b0, 5'd2, 5'd0, 5'd5);        // LW x5
        tick();
        set_id(1'b1, OP_OP, 3'd0, 1'b0, 5'd5, 5'd1, 5'd6);          // ADD x6,x5,x1
        #1;
        checks++; if (o_id_ready !== 1'b0) begin errors++; $display("FAIL lu_stall: got %0b want 0", o_id_ready); end
        checks++; if (o_ex_valid !== 1'b1 || o_alu_op !== 3'd0) begin errors++; $display("FAIL lu_load_issue: got ex_valid=%0b alu_op=%0d want 1/0", o_ex_valid, o_alu_op); end
        tick();
        set_fwd(5'd0, 1'b0, 5'd5, 1'b1);
        #1;
        checks++; if (o_id_ready !== 1'b1 || o_ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got ready=%0b ex_valid=%0b want 1/0", o_id_ready, o_ex_valid); end
        tick();
        idle();
        set_fwd(5'd0, 1'b0, 5'd0, 1'b0);
        checks++; if (o_ex_valid !== 1'b1 || o_alu_op !== 3'd2) begin errors++; $display("FAIL lu_add_issue: got ex_valid=%0b alu_op=%0d want 1/2", o_ex_valid, o_alu_op); end
        checks++; if (o_fwd_a !== 2'd2 || o_fwd_b !== 2'd0) begin errors++; $display("FAIL lu_fwd: got a=%0d b=%0d want 2/0", o_fwd_a, o_fwd_b); end
        tick();
        // LUI reads no register, so its rs fields must not trigger a stall.
        set_id(1'b1, OP_LOAD, 3'd2, 1'b0, 5'd2, 5'd0, 5'd5);
        tick();
        set_id(1'b1, OP_LUI, 3'd0, 1'b0, 5'd5, 5'd5, 5'd7);
        #1;
        checks++; if (o_id_ready !== 1'b1) begin errors++; $display("FAIL lui_no_stall: got %0b want 1", o_id_ready); end
        tick();
        idle();
        checks++; if (o_alu_op !== 3'd4 || o_ex_valid !== 1'b1) begin errors++; $display("FAIL lui_issue: got alu_op=%0d ex_valid=%0b want 4/1", o_alu_op, o_ex_valid); end
        tick();
    endtask

    task automatic test_forwarding;
        set_fwd(5'd7, 1'b1, 5'd7, 1'b1);
        set_id(1'b1, OP_OP, 3'd0, 1'b0, 5'd3, 5'd7, 5'd8);
        tick();
        set_fwd(5'd0, 1'b1, 5'd9, 1'b1);
        set_id(1'b1, OP_OP, 3'd0, 1'b0, 5'd9, 5'd0, 5'd8);
        checks++; if (o_fwd_b !== 2'd1 || o_fwd_a !== 2'd0) begin errors++; $display("FAIL fwd_mem_prio: got a=%0d b=%0d want 0/1", o_fwd_a, o_fwd_b); end
        tick();
        set_fwd(5'd3, 1'b0, 5'd3, 1'b0);
        set_id(1'b1, OP_OP, 3'd0, 1'b0, 5'd3, 5'd3, 5'd8);
        checks++; if (o_fwd_a !== 2'd2 || o_fwd_b !== 2'd0) begin errors++; $display("FAIL fwd_wb_x0: got a=%0d b=%0d want 2/0", o_fwd_a, o_fwd_b); end
        tick();
        idle();
        set_fwd(5'd0, 1'b0, 5'd0, 1'b0);
        checks++; if (o_fwd_a !== 2'd0 || o_fwd_b !== 2'd0) begin errors++; $display("FAIL fwd_no_regwrite: got a=%0d b=%0d want 0/0", o_fwd_a, o_fwd_b); end
        tick();
    endtask

    task automatic test_illegal;
        set_id(1'b1, 7'h7F, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        checks++; if (o_id_ready !== 1'b1) begin errors++; $display("FAIL ill_ready: got %0b want 1", o_id_ready); end
        tick();
        set_id(1'b1, OP_OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3);
        checks++; if (o_illegal !== 1'b1 || o_ex_valid !== 1'b0) begin errors++; $display("FAIL ill_pulse: got illegal=%0b ex_valid=%0b want 1/0", o_illegal, o_ex_valid); end
        #1;
        checks++; if (o_id_ready !== 1'b1) begin errors++; $display("FAIL ill_state_run: got %0b want 1", o_id_ready); end
        tick();
        idle();
        checks++; if (o_illegal !== 1'b0 || o_ex_valid !== 1'b1) begin errors++; $display("FAIL ill_after: got illegal=%0b ex_valid=%0b want 0/1", o_illegal, o_ex_valid); end
        tick();
    endtask

    task automatic test_flush_reset;
        set_id(1'b1, OP_BRANCH, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        idle();
        tick();
        i_alu_branch = 1'b1;
        i_alu_result = 32'h80;
        tick();
        i_alu_branch = 1'b0;
        i_alu_result = 32'd0;
        set_id(1'b1, OP_OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3);
        checks++; if (o_squash !== 1'b1) begin errors++; $display("FAIL fr_in_flush: got %0b want 1", o_squash); end
        tick();
        i_reset = 1'b0;
        idle();
        checks++; if (o_squash !== 1'b1) begin errors++; $display("FAIL fr_count1: got %0b want 1", o_squash); end
        tick();
        checks++; if (o_squash !== 1'b0 || o_redirect !== 1'b0 || o_id_ready !== 1'b0) begin errors++; $display("FAIL fr_reset_ctrl: got squash=%0b redirect=%0b ready=%0b want 0/0/0", o_squash, o_redirect, o_id_ready); end
        checks++; if (o_target !== 32'd0 || o_ex_valid !== 1'b0 || o_alu_op !== 3'd0 || o_illegal !== 1'b0) begin errors++; $display("FAIL fr_reset_regs: got target=%h ex_valid=%0b alu_op=%0d illegal=%0b want 0", o_target, o_ex_valid, o_alu_op, o_illegal); end
        i_reset = 1'b1;
        #1;
        checks++; if (o_id_ready !== 1'b1) begin errors++; $display("FAIL fr_run: got %0b want 1", o_id_ready); end
        tick();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_branch_taken();
        test_branch_not_taken();
        test_jalr();
        test_load_use();
        test_forwarding();
        test_illegal();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
